// File: rtl/stream_pattern_gen.sv
// Dual-channel AXI-Stream test-pattern source (counter / PRBS / constant) with an
// IPIF register bank for control, word limit, seed and status.
module stream_pattern_gen #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned N_REG              = 5
) (
  input  logic                            clk,
  input  logic                            reset,

  output logic [31:0]                     M_AXIS_0_TDATA,
  output logic                            M_AXIS_0_TVALID,
  input  logic                            M_AXIS_0_TREADY,
  output logic [31:0]                     M_AXIS_1_TDATA,
  output logic                            M_AXIS_1_TVALID,
  input  logic                            M_AXIS_1_TREADY,

  input  logic                            IPIF_Bus2IP_resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   IPIF_Bus2IP_Addr,
  input  logic                            IPIF_Bus2IP_RNW,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] IPIF_Bus2IP_BE,
  input  logic                            IPIF_Bus2IP_CS,
  input  logic [N_REG-1:0]                IPIF_Bus2IP_RdCE,
  input  logic [N_REG-1:0]                IPIF_Bus2IP_WrCE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_IP2Bus_Data,
  output logic                            IPIF_IP2Bus_WrAck,
  output logic                            IPIF_IP2Bus_RdAck,
  output logic                            IPIF_IP2Bus_Error
);

  localparam logic [31:0] PrbsTaps = 32'h0040_0007;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  typedef enum logic [1:0] {ModeCounter = 2'd0, ModePrbs = 2'd1, ModeConst = 2'd2,
                            ModeCounterAlt = 2'd3} mode_e;

  // Register bank
  logic [31:0] mode_reg_q, limit_reg_q, seed_reg_q;
  logic        cmd_start, cmd_stop, cmd_inject;

  always_ff @(posedge clk) begin
    if (!IPIF_Bus2IP_resetn) begin
      mode_reg_q  <= '0;
      limit_reg_q <= '0;
      seed_reg_q  <= '0;
    end else begin
      if (IPIF_Bus2IP_WrCE[1]) mode_reg_q  <= IPIF_Bus2IP_Data[31:0];
      if (IPIF_Bus2IP_WrCE[2]) limit_reg_q <= IPIF_Bus2IP_Data[31:0];
      if (IPIF_Bus2IP_WrCE[3]) seed_reg_q  <= IPIF_Bus2IP_Data[31:0];
    end
  end

  // reg0 is a write-pulse register: commands last only for the write cycle
  assign cmd_start  = IPIF_Bus2IP_WrCE[0] & IPIF_Bus2IP_Data[0];
  assign cmd_stop   = IPIF_Bus2IP_WrCE[0] & IPIF_Bus2IP_Data[1];
  assign cmd_inject = IPIF_Bus2IP_WrCE[0] & IPIF_Bus2IP_Data[2];

  // Core state
  state_e      state_q;
  mode_e       mode_q;
  logic [31:0] gen_q;
  logic [30:0] words_sent_q;
  logic        inject_q;
  logic [31:0] tdata0_q, tdata1_q;
  logic        tvalid0_q, tvalid1_q;

  logic        busy;
  logic        free0, free1, issue, limit_hit, drain_done;
  logic [30:0] words_inc;
  logic [31:0] gen_next, seed_load;

  assign busy       = (state_q != StIdle);
  assign free0      = ~tvalid0_q | M_AXIS_0_TREADY;
  assign free1      = ~tvalid1_q | M_AXIS_1_TREADY;
  assign issue      = (state_q == StRun) & free0 & free1;
  assign words_inc  = words_sent_q + 31'd1;
  assign limit_hit  = (limit_reg_q != 32'd0) && ({1'b0, words_inc} == limit_reg_q);
  // Both channels will have no word outstanding after this edge
  assign drain_done = ~(tvalid0_q & ~M_AXIS_0_TREADY) & ~(tvalid1_q & ~M_AXIS_1_TREADY);

  // PRBS cannot run from the all-zero state
  assign seed_load = ((mode_reg_q[1:0] == ModePrbs) && (seed_reg_q == 32'd0)) ? 32'd1
                                                                              : seed_reg_q;

  always_comb begin
    gen_next = gen_q + 32'd1;
    unique case (mode_q)
      ModePrbs:  gen_next = {gen_q[30:0], 1'b0} ^ (gen_q[31] ? PrbsTaps : 32'd0);
      ModeConst: gen_next = gen_q;
      default:   gen_next = gen_q + 32'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      mode_q       <= ModeCounter;
      gen_q        <= '0;
      words_sent_q <= '0;
      inject_q     <= 1'b0;
      tdata0_q     <= '0;
      tdata1_q     <= '0;
      tvalid0_q    <= 1'b0;
      tvalid1_q    <= 1'b0;
    end else begin
      if (cmd_inject) inject_q <= 1'b1;
      // Retire accepted words; an issue below overrides this
      if (tvalid0_q && M_AXIS_0_TREADY) tvalid0_q <= 1'b0;
      if (tvalid1_q && M_AXIS_1_TREADY) tvalid1_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (cmd_start) begin
            gen_q        <= seed_load;
            mode_q       <= mode_e'(mode_reg_q[1:0]);
            words_sent_q <= '0;
            state_q      <= StRun;
          end
        end
        StRun: begin
          if (issue) begin
            tdata0_q     <= gen_q;
            tdata1_q     <= gen_q ^ {31'd0, inject_q};
            tvalid0_q    <= 1'b1;
            tvalid1_q    <= 1'b1;
            words_sent_q <= words_inc;
            gen_q        <= gen_next;
            // A fresh inject arriving with this issue stays pending for the next word
            inject_q     <= cmd_inject;
            if (limit_hit) state_q <= StDrain;
          end
          if (cmd_stop) state_q <= StDrain;
        end
        StDrain: begin
          if (drain_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign M_AXIS_0_TDATA  = tdata0_q;
  assign M_AXIS_0_TVALID = tvalid0_q;
  assign M_AXIS_1_TDATA  = tdata1_q;
  assign M_AXIS_1_TVALID = tvalid1_q;

  // Register read-back
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (IPIF_Bus2IP_RdCE[1]) rd_data = mode_reg_q;
    if (IPIF_Bus2IP_RdCE[2]) rd_data = limit_reg_q;
    if (IPIF_Bus2IP_RdCE[3]) rd_data = seed_reg_q;
    if (IPIF_Bus2IP_RdCE[4]) rd_data = {busy, words_sent_q};
  end

  assign IPIF_IP2Bus_Data  = rd_data;
  assign IPIF_IP2Bus_WrAck = |IPIF_Bus2IP_WrCE;
  assign IPIF_IP2Bus_RdAck = |IPIF_Bus2IP_RdCE;
  assign IPIF_IP2Bus_Error = 1'b0;

  logic unused_ipif;
  assign unused_ipif = ^{IPIF_Bus2IP_Addr, IPIF_Bus2IP_RNW, IPIF_Bus2IP_BE, IPIF_Bus2IP_CS};

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Directed bench for stream_pattern_gen: register setup, per-channel handshakes,
// generator modes, inject, stop and reset behaviour.
module tb_stream_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] td0, td1;
  logic        tv0, tv1, tr0, tr1;
  logic        resetn;
  logic [31:0] addr;
  logic        rnw, cs;
  logic [3:0]  be;
  logic [4:0]  rdce, wrce;
  logic [31:0] wdata, rd_data;
  logic        wrack, rdack, bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] rv;
  logic        last_rdack;

  stream_pattern_gen dut (
    .clk                (clk),
    .reset              (reset),
    .M_AXIS_0_TDATA     (td0),
    .M_AXIS_0_TVALID    (tv0),
    .M_AXIS_0_TREADY    (tr0),
    .M_AXIS_1_TDATA     (td1),
    .M_AXIS_1_TVALID    (tv1),
    .M_AXIS_1_TREADY    (tr1),
    .IPIF_Bus2IP_resetn (resetn),
    .IPIF_Bus2IP_Addr   (addr),
    .IPIF_Bus2IP_RNW    (rnw),
    .IPIF_Bus2IP_BE     (be),
    .IPIF_Bus2IP_CS     (cs),
    .IPIF_Bus2IP_RdCE   (rdce),
    .IPIF_Bus2IP_WrCE   (wrce),
    .IPIF_Bus2IP_Data   (wdata),
    .IPIF_IP2Bus_Data   (rd_data),
    .IPIF_IP2Bus_WrAck  (wrack),
    .IPIF_IP2Bus_RdAck  (rdack),
    .IPIF_IP2Bus_Error  (bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      if (tv0 && tr0) q0.push_back(td0);
      if (tv1 && tr1) q1.push_back(td1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic reg_write(input int idx, input logic [31:0] d);
    @(negedge clk);
    wrce  = 5'(1 << idx);
    wdata = d;
    @(negedge clk);
    wrce  = '0;
    wdata = '0;
  endtask

  task automatic reg_read(input int idx, output logic [31:0] d);
    @(negedge clk);
    rdce = 5'(1 << idx);
    #1;
    d = rd_data;
    last_rdack = rdack;
    rdce = '0;
  endtask

  task automatic clear_q();
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int n_bad;
    int n_inj;
    logic [30:0] ws;
    logic stopped;

    reset = 1'b1; resetn = 1'b0;
    addr = '0; rnw = 1'b0; cs = 1'b0; be = '0;
    rdce = '0; wrce = '0; wdata = '0;
    tr0 = 1'b1; tr1 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; resetn = 1'b1;

    // Reset state
    check("rst_tvalid0", 32'(tv0), 32'd0);
    check("rst_tvalid1", 32'(tv1), 32'd0);
    check("rst_tdata0", td0, 32'd0);
    check("rst_tdata1", td1, 32'd0);
    check("rst_error", 32'(bus_err), 32'd0);
    reg_read(4, rv);
    check("rst_status", rv, 32'd0);
    check("rd_ack", 32'(last_rdack), 32'd1);
    reg_read(1, rv);
    check("rst_mode", rv, 32'd0);

    // Counter, seed 0x10, limit 4, one word per cycle
    reg_write(1, 32'd0);
    reg_write(2, 32'd4);
    reg_write(3, 32'h10);
    clear_q();
    reg_write(0, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cnt_tdata0", td0, 32'h10 + 32'(i));
      check("cnt_tdata1", td1, 32'h10 + 32'(i));
      check("cnt_tvalid0", 32'(tv0), 32'd1);
      check("cnt_tvalid1", 32'(tv1), 32'd1);
    end
    @(negedge clk);
    check("cnt_end_tvalid0", 32'(tv0), 32'd0);
    check("cnt_end_tvalid1", 32'(tv1), 32'd0);
    reg_read(4, rv);
    check("cnt_status", rv, 32'h0000_0004);
    check("cnt_q0_size", 32'(q0.size()), 32'd4);

    // Counter, seed 0, limit 3, channel 1 stalled on the first word
    reg_write(2, 32'd3);
    reg_write(3, 32'd0);
    clear_q();
    tr1 = 1'b0;
    reg_write(0, 32'h1);
    @(negedge clk);
    check("stall_w0_tvalid0", 32'(tv0), 32'd1);
    check("stall_w0_tdata0", td0, 32'd0);
    @(negedge clk);
    check("stall_ch0_drop", 32'(tv0), 32'd0);
    check("stall_ch1_hold", 32'(tv1), 32'd1);
    check("stall_ch1_data", td1, 32'd0);
    @(negedge clk);
    check("stall_no_w1_a", 32'(tv0), 32'd0);
    @(negedge clk);
    check("stall_no_w1_b", 32'(tv0), 32'd0);
    tr1 = 1'b1;
    repeat (6) @(negedge clk);
    check("stall_q0_size", 32'(q0.size()), 32'd3);
    check("stall_q1_size", 32'(q1.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("stall_q0_word", qat(q0, i), 32'(i));
      check("stall_q1_word", qat(q1, i), 32'(i));
    end

    // PRBS, seed 0x80000000
    reg_write(1, 32'd1);
    reg_write(3, 32'h8000_0000);
    clear_q();
    reg_write(0, 32'h1);
    repeat (8) @(negedge clk);
    check("prbs_w0", qat(q0, 0), 32'h8000_0000);
    check("prbs_w1", qat(q0, 1), 32'h0040_0007);
    check("prbs_w2", qat(q0, 2), 32'h0080_000E);
    check("prbs_ch1_w2", qat(q1, 2), 32'h0080_000E);

    // PRBS, zero seed replaced by 1
    reg_write(3, 32'd0);
    clear_q();
    reg_write(0, 32'h1);
    repeat (8) @(negedge clk);
    check("prbs0_w0", qat(q0, 0), 32'h1);
    check("prbs0_ch1_w0", qat(q1, 0), 32'h1);
    check("prbs0_w1", qat(q0, 1), 32'h2);

    // Constant with one inject mid-run
    reg_write(1, 32'd2);
    reg_write(2, 32'd8);
    reg_write(3, 32'hA5A5_A5A5);
    clear_q();
    reg_write(0, 32'h1);
    repeat (2) @(negedge clk);
    reg_write(0, 32'h4);
    repeat (12) @(negedge clk);
    n_bad = 0;
    n_inj = 0;
    foreach (q0[i]) if (q0[i] !== 32'hA5A5_A5A5) n_bad++;
    foreach (q1[i]) if (q1[i] === 32'hA5A5_A5A4) n_inj++;
    check("inj_q0_size", 32'(q0.size()), 32'd8);
    check("inj_q1_size", 32'(q1.size()), 32'd8);
    check("inj_ch0_clean", 32'(n_bad), 32'd0);
    check("inj_ch1_once", 32'(n_inj), 32'd1);

    // Unlimited counter, stop at 10 words with toggling readies
    reg_write(1, 32'd0);
    reg_write(2, 32'd0);
    reg_write(3, 32'h100);
    clear_q();
    reg_write(0, 32'h1);
    stopped = 1'b0;
    for (int c = 0; c < 300 && !stopped; c++) begin
      @(negedge clk);
      tr0 = c[0];
      tr1 = (c % 3) != 0;
      rdce = 5'b10000;
      #1;
      ws = rd_data[30:0];
      rdce = '0;
      if (ws == 31'd9 && (!tv0 || tr0) && (!tv1 || tr1)) begin
        wrce = 5'b00001;
        wdata = 32'h2;
        stopped = 1'b1;
      end
    end
    check("stop_reached", 32'(stopped), 32'd1);
    @(negedge clk);
    wrce = '0;
    wdata = '0;
    tr0 = 1'b1;
    tr1 = 1'b1;
    repeat (6) @(negedge clk);
    reg_read(4, rv);
    check("stop_status", rv, 32'h0000_000A);
    check("stop_q0_size", 32'(q0.size()), 32'd10);
    check("stop_q1_size", 32'(q1.size()), 32'd10);
    check("stop_q0_last", qat(q0, 9), 32'h109);
    check("stop_q1_last", qat(q1, 9), 32'h109);

    // Restart from the seed
    clear_q();
    reg_write(0, 32'h1);
    repeat (3) @(negedge clk);
    reg_write(0, 32'h2);
    repeat (6) @(negedge clk);
    check("restart_q0_w0", qat(q0, 0), 32'h100);
    check("restart_q1_w0", qat(q1, 0), 32'h100);

    // Reset while both channels hold a word
    reg_write(1, 32'd2);
    reg_write(3, 32'hDEAD_BEEF);
    tr0 = 1'b0;
    tr1 = 1'b0;
    reg_write(0, 32'h1);
    repeat (3) @(negedge clk);
    check("mid_tvalid0", 32'(tv0), 32'd1);
    check("mid_tvalid1", 32'(tv1), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tvalid0", 32'(tv0), 32'd0);
    check("mid_rst_tvalid1", 32'(tv1), 32'd0);
    check("mid_rst_tdata0", td0, 32'd0);
    reset = 1'b0;
    reg_read(4, rv);
    check("mid_rst_status", rv, 32'd0);
    reg_read(1, rv);
    check("mid_rst_reg1", rv, 32'd2);
    reg_read(2, rv);
    check("mid_rst_reg2", rv, 32'd0);
    reg_read(3, rv);
    check("mid_rst_reg3", rv, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
